// File: rtl/sha256_msg_padder_pkg.sv
// Shared constants for the SHA-256 message padder and the compression core
// that sits downstream of it.
package sha256_msg_padder_pkg;

  localparam int unsigned SHA256_BLK_W     = 512;
  localparam int unsigned SHA256_BLK_BYTES = 64;
  localparam int unsigned SHA256_LEN_POS   = 56;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  // H0..H7 packed big-endian; consumed by the compression core on blk_first.
  localparam logic [255:0] SHA256_H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-in / block-out handshake bundle between the message source, the padder
// and the SHA-256 compression core.
interface sha256_msg_padder_if;
  import sha256_msg_padder_pkg::*;

  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_empty;
  logic                    in_ready;
  logic [SHA256_BLK_W-1:0] blk_data;
  logic                    blk_valid;
  logic                    blk_ready;
  logic                    blk_first;
  logic                    blk_last;

  modport slave (
    input  in_data, in_valid, in_last, in_empty, blk_ready,
    output in_ready, blk_data, blk_valid, blk_first, blk_last
  );

  modport master (
    output in_data, in_valid, in_last, in_empty, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_first, blk_last
  );

endinterface

// File: rtl/sha256_pad_tail.sv
// Builds a padded block: keeps bytes below p, puts 0x80 at p unless already
// placed, zero-fills the rest and inserts the bit length when it fits.
module sha256_pad_tail
  import sha256_msg_padder_pkg::*;
(
  input  logic [SHA256_BLK_W-1:0] buf_in,
  input  logic [6:0]              p,
  input  logic                    pad_done,
  input  logic [63:0]             bit_len,
  output logic [SHA256_BLK_W-1:0] blk_out,
  output logic                    len_fit
);

  assign len_fit = (p <= 7'(SHA256_LEN_POS - 1));

  always_comb begin
    blk_out = '0;
    for (int unsigned i = 0; i < SHA256_BLK_BYTES; i++) begin
      if (i < 32'(p))
        blk_out[(SHA256_BLK_BYTES-1-i)*8 +: 8] = buf_in[(SHA256_BLK_BYTES-1-i)*8 +: 8];
      else if ((i == 32'(p)) && !pad_done)
        blk_out[(SHA256_BLK_BYTES-1-i)*8 +: 8] = 8'h80;
    end
    if (len_fit)
      blk_out[63:0] = bit_len;
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 front end: packs message bytes into 512-bit blocks, applies FIPS
// 180-4 padding and hands blocks to the compression core with first/last tags.
module sha256_msg_padder #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                CLK,
  input  logic                nreset,
  sha256_msg_padder_if.slave  bus
);
  import sha256_msg_padder_pkg::*;

  logic [1:0]              state;
  logic [6:0]              idx;
  logic [CNT_W-1:0]        byte_cnt;
  logic [SHA256_BLK_W-1:0] buffer;
  logic                    first_pend;
  logic                    pad_done;
  logic                    last;
  logic                    tail_pend;

  logic [SHA256_BLK_W-1:0] pad_blk;
  logic                    len_fit;
  logic [63:0]             bit_len;
  logic [6:0]              pad_p;
  logic [8:0]              wr_lsb;
  logic                    in_fire;
  logic                    out_fire;

  assign bus.in_ready  = (state == S_FILL);
  assign bus.blk_valid = (state == S_EMIT);
  assign bus.blk_data  = buffer;
  assign bus.blk_first = (state == S_EMIT) && first_pend;
  assign bus.blk_last  = (state == S_EMIT) && last;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.blk_valid && bus.blk_ready;

  assign bit_len = 64'({byte_cnt, 3'b000});
  // Byte k lives at bits [(63-k)*8 +: 8]; for k<64, 63-k is just ~k.
  assign wr_lsb  = {~idx[5:0], 3'b000};
  // The tail block reuses the pad builder with p=0 so nothing is carried over.
  assign pad_p   = (state == S_TAIL) ? '0 : idx;

  sha256_pad_tail u_pad_tail (
    .buf_in   (buffer),
    .p        (pad_p),
    .pad_done (pad_done),
    .bit_len  (bit_len),
    .blk_out  (pad_blk),
    .len_fit  (len_fit)
  );

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state      <= S_FILL;
      idx        <= '0;
      byte_cnt   <= '0;
      buffer     <= '0;
      first_pend <= 1'b1;
      pad_done   <= 1'b0;
      last       <= 1'b0;
      tail_pend  <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_fire) begin
            if (!bus.in_empty) begin
              buffer[wr_lsb +: 8] <= bus.in_data;
              idx                 <= idx + 7'd1;
              byte_cnt            <= byte_cnt + CNT_W'(1);
            end
            if (bus.in_last) begin
              state <= S_PAD;
            end else if (!bus.in_empty && (idx == 7'd63)) begin
              last  <= 1'b0;
              state <= S_EMIT;
            end
          end
        end
        S_PAD: begin
          buffer    <= pad_blk;
          if (!idx[6])
            pad_done <= 1'b1;
          last      <= len_fit;
          tail_pend <= !len_fit;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_fire) begin
            first_pend <= 1'b0;
            if (tail_pend) begin
              state <= S_TAIL;
            end else if (last) begin
              idx        <= '0;
              byte_cnt   <= '0;
              pad_done   <= 1'b0;
              first_pend <= 1'b1;
              state      <= S_FILL;
            end else begin
              idx   <= '0;
              state <= S_FILL;
            end
          end
        end
        S_TAIL: begin
          buffer    <= pad_blk;
          last      <= 1'b1;
          tail_pend <= 1'b0;
          state     <= S_EMIT;
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
